// File: rtl/cart_bus_arbiter.sv
// Two-requester (core / debug) arbiter for the cartridge bus with programmable
// setup, strobe and hold phases; one transaction at a time, arbitrated only in IDLE.
module cart_bus_arbiter #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic        core_ack,
  output logic [7:0]  core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_oe,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        bus_cs
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;
  logic        gnt_dbg_q, gnt_dbg_d;
  logic [7:0]  core_rdata_q, core_rdata_d;
  logic [7:0]  dbg_rdata_q, dbg_rdata_d;
  logic        pick_dbg;

  // Debug wins when it is the only requester, or when the core is halted.
  assign pick_dbg = dbg_req && (halt || !core_req);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    we_d         = we_q;
    gnt_dbg_d    = gnt_dbg_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (core_req || dbg_req) begin
          gnt_dbg_d = pick_dbg;
          addr_d    = pick_dbg ? dbg_addr  : core_addr;
          we_d      = pick_dbg ? dbg_we    : core_we;
          dout_d    = pick_dbg ? dbg_wdata : core_wdata;
          state_d   = SETUP;
          cnt_d     = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_dbg_q) dbg_rdata_d  = bus_din;
            else           core_rdata_d = bus_din;
          end
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 16'h0000;
      dout_q       <= 8'h00;
      we_q         <= 1'b0;
      gnt_dbg_q    <= 1'b0;
      core_rdata_q <= 8'h00;
      dbg_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      we_q         <= we_d;
      gnt_dbg_q    <= gnt_dbg_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  logic active;
  logic last_hold;
  assign active    = (state_q != IDLE);
  assign last_hold = (state_q == HOLD) && (cnt_q == 4'd0);

  assign bus_a      = addr_q;
  assign bus_dout   = dout_q;
  assign bus_rd     = !we_q && ((state_q == SETUP) || (state_q == STROBE));
  assign bus_wr     = we_q && (state_q == STROBE);
  assign bus_oe     = we_q && active;
  assign bus_cs     = active && (addr_q[15:13] == 3'b101);
  assign core_ack   = last_hold && !gnt_dbg_q;
  assign dbg_ack    = last_hold && gnt_dbg_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: default timing instance plus a 1/1/1 instance.
module tb_cart_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [15:0] core_addr = 16'h0;
  logic [7:0]  core_wdata = 8'h0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = 16'h0;
  logic [7:0]  dbg_wdata = 8'h0;
  logic [7:0]  bus_din = 8'h0;

  logic        core_ack, dbg_ack, bus_oe, bus_rd, bus_wr, bus_cs;
  logic [7:0]  core_rdata, dbg_rdata, bus_dout;
  logic [15:0] bus_a;

  logic        f_core_ack, f_dbg_ack, f_bus_oe, f_bus_rd, f_bus_wr, f_bus_cs;
  logic [7:0]  f_core_rdata, f_dbg_rdata, f_bus_dout;
  logic [15:0] f_bus_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cart_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_din(bus_din), .bus_oe(bus_oe),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_cs(bus_cs)
  );

  cart_bus_arbiter #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(f_core_ack), .core_rdata(f_core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(f_dbg_ack), .dbg_rdata(f_dbg_rdata),
    .bus_a(f_bus_a), .bus_dout(f_bus_dout), .bus_din(bus_din), .bus_oe(f_bus_oe),
    .bus_rd(f_bus_rd), .bus_wr(f_bus_wr), .bus_cs(f_bus_cs)
  );

  // Per-cycle observations, cycle 1 = first cycle after the grant cycle.
  logic        rd_at [0:31];
  logic        wr_at [0:31];
  logic        f_rd_at [0:31];
  logic [15:0] a_at [0:31];
  logic [7:0]  dout_at [0:31];
  int rd_cnt, wr_cnt, cs_cnt, oe_cnt;
  int core_acks[$];
  int dbg_acks[$];
  int f_acks[$];

  // Caller raises requests just before a rising edge (the grant edge).
  // A requester's req is dropped on the cycle of its ack once keep_core acks have passed.
  task automatic observe(input int ncyc, input int keep_core, input bit drop_early,
                         input int halt_at, input int cap_cyc, input logic [7:0] din_good);
    rd_cnt = 0; wr_cnt = 0; cs_cnt = 0; oe_cnt = 0;
    core_acks.delete(); dbg_acks.delete(); f_acks.delete();
    for (int i = 0; i < 32; i++) begin
      rd_at[i] = 1'b0; wr_at[i] = 1'b0; f_rd_at[i] = 1'b0; a_at[i] = 16'h0; dout_at[i] = 8'h0;
    end
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      rd_at[i] = bus_rd; wr_at[i] = bus_wr; f_rd_at[i] = f_bus_rd;
      a_at[i] = bus_a; dout_at[i] = bus_dout;
      rd_cnt += int'(bus_rd); wr_cnt += int'(bus_wr);
      cs_cnt += int'(bus_cs); oe_cnt += int'(bus_oe);
      if (core_ack) begin
        core_acks.push_back(i);
        if (core_acks.size() > keep_core) core_req = 1'b0;
      end
      if (dbg_ack) begin
        dbg_acks.push_back(i);
        dbg_req = 1'b0;
      end
      if (f_core_ack) f_acks.push_back(i);
      if (i == 1 && drop_early) begin
        core_req = 1'b0; core_addr = 16'hFFFF; core_we = ~core_we; core_wdata = 8'h00;
      end
      if (i == halt_at) halt = 1'b1;
      if (cap_cyc != 0) bus_din = (i == cap_cyc) ? din_good : ~din_good;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a !== 16'h0 || bus_dout !== 8'h0 || bus_rd !== 1'b0 || bus_wr !== 1'b0 ||
        bus_cs !== 1'b0 || bus_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: a=%h dout=%h rd=%b wr=%b cs=%b oe=%b, want all 0",
               bus_a, bus_dout, bus_rd, bus_wr, bus_cs, bus_oe);
    end
    checks++;
    if (core_ack !== 1'b0 || dbg_ack !== 1'b0 || core_rdata !== 8'h0 || dbg_rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_req: core_ack=%b dbg_ack=%b core_rdata=%h dbg_rdata=%h, want 0",
               core_ack, dbg_ack, core_rdata, dbg_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_core_read();
    core_addr = 16'h0150; core_we = 1'b0; core_req = 1'b1; bus_din = 8'hC3;
    observe(10, 0, 1'b0, 0, 6, 8'h3C);
    $display("core_read: acks=%0d rd_cnt=%0d rdata=%h", core_acks.size(), rd_cnt, core_rdata);
    checks++;
    if (rd_cnt != 6 || rd_at[1] !== 1'b1 || rd_at[7] !== 1'b0) begin
      errors++; $display("FAIL read_rd: cnt=%0d c1=%b c7=%b, want 6 1 0", rd_cnt, rd_at[1], rd_at[7]);
    end
    checks++;
    if (cs_cnt != 0 || oe_cnt != 0 || wr_cnt != 0) begin
      errors++; $display("FAIL read_cs_oe_wr: cs=%0d oe=%0d wr=%0d, want 0 0 0", cs_cnt, oe_cnt, wr_cnt);
    end
    checks++;
    if (core_acks.size() != 1 || core_acks[0] != 7 || dbg_acks.size() != 0) begin
      errors++; $display("FAIL read_ack: n=%0d at=%0d dbg_n=%0d, want 1 7 0",
                         core_acks.size(), core_acks[0], dbg_acks.size());
    end
    checks++;
    if (core_rdata !== 8'h3C) begin
      errors++; $display("FAIL read_data: got %h want 3c", core_rdata);
    end
    checks++;
    if (a_at[1] !== 16'h0150 || a_at[8] !== 16'h0150) begin
      errors++; $display("FAIL read_addr: c1=%h c8=%h want 0150", a_at[1], a_at[8]);
    end
  endtask

  task automatic test_core_write();
    core_addr = 16'hA000; core_we = 1'b1; core_wdata = 8'h5A; core_req = 1'b1; bus_din = 8'h11;
    observe(10, 0, 1'b0, 0, 0, 8'h00);
    $display("core_write: acks=%0d wr_cnt=%0d cs_cnt=%0d oe_cnt=%0d", core_acks.size(), wr_cnt, cs_cnt, oe_cnt);
    checks++;
    if (cs_cnt != 7 || oe_cnt != 7) begin
      errors++; $display("FAIL write_cs_oe: cs=%0d oe=%0d want 7 7", cs_cnt, oe_cnt);
    end
    checks++;
    if (wr_cnt != 4 || wr_at[2] !== 1'b0 || wr_at[3] !== 1'b1 || rd_cnt != 0) begin
      errors++; $display("FAIL write_wr: cnt=%0d c2=%b c3=%b rd=%0d want 4 0 1 0",
                         wr_cnt, wr_at[2], wr_at[3], rd_cnt);
    end
    checks++;
    if (dout_at[1] !== 8'h5A || dout_at[7] !== 8'h5A) begin
      errors++; $display("FAIL write_dout: c1=%h c7=%h want 5a", dout_at[1], dout_at[7]);
    end
    checks++;
    if (core_acks.size() != 1 || core_acks[0] != 7) begin
      errors++; $display("FAIL write_ack: n=%0d at=%0d want 1 7", core_acks.size(), core_acks[0]);
    end
    checks++;
    if (core_rdata !== 8'h3C) begin
      errors++; $display("FAIL write_keeps_rdata: got %h want 3c", core_rdata);
    end
    core_we = 1'b0;
  endtask

  task automatic test_priority(input logic h);
    halt = h; bus_din = 8'h77;
    core_addr = 16'h0100; core_we = 1'b0; core_req = 1'b1;
    dbg_addr = 16'hB000; dbg_we = 1'b0; dbg_req = 1'b1;
    observe(17, 0, 1'b0, 0, 0, 8'h00);
    $display("priority halt=%b: core_ack@%0d dbg_ack@%0d", h, core_acks[0], dbg_acks[0]);
    checks++;
    if (core_acks.size() != 1 || dbg_acks.size() != 1 ||
        core_acks[0] != (h ? 15 : 7) || dbg_acks[0] != (h ? 7 : 15)) begin
      errors++; $display("FAIL prio_order_h%b: core@%0d dbg@%0d want %0d %0d",
                         h, core_acks[0], dbg_acks[0], h ? 15 : 7, h ? 7 : 15);
    end
    checks++;
    if (a_at[1] !== (h ? 16'hB000 : 16'h0100) || a_at[9] !== (h ? 16'h0100 : 16'hB000) ||
        rd_at[8] !== 1'b0 || rd_at[9] !== 1'b1) begin
      errors++; $display("FAIL prio_gap_h%b: a1=%h a9=%h rd8=%b rd9=%b", h, a_at[1], a_at[9], rd_at[8], rd_at[9]);
    end
    checks++;
    if (dbg_rdata !== 8'h77 || core_rdata !== 8'h77 || cs_cnt != 7) begin
      errors++; $display("FAIL prio_data_h%b: dbg=%h core=%h cs=%0d want 77 77 7", h, dbg_rdata, core_rdata, cs_cnt);
    end
    halt = 1'b0;
  endtask

  task automatic test_halt_mid();
    halt = 1'b0; bus_din = 8'h3C;
    core_addr = 16'h0200; core_we = 1'b0; core_req = 1'b1;
    dbg_addr = 16'hA800; dbg_we = 1'b0; dbg_req = 1'b1;
    observe(17, 0, 1'b0, 4, 6, 8'hC3);
    $display("halt_mid: core_ack@%0d dbg_ack@%0d core_rdata=%h", core_acks[0], dbg_acks[0], core_rdata);
    checks++;
    if (core_acks.size() != 1 || core_acks[0] != 7 || core_rdata !== 8'hC3 || a_at[5] !== 16'h0200) begin
      errors++; $display("FAIL halt_mid_core: ack@%0d rdata=%h a5=%h want 7 c3 0200",
                         core_acks[0], core_rdata, a_at[5]);
    end
    checks++;
    if (dbg_acks.size() != 1 || dbg_acks[0] != 15 || a_at[9] !== 16'hA800) begin
      errors++; $display("FAIL halt_mid_dbg: ack@%0d a9=%h want 15 a800", dbg_acks[0], a_at[9]);
    end
    halt = 1'b0;
  endtask

  task automatic test_drop_mid();
    core_addr = 16'hA010; core_we = 1'b1; core_wdata = 8'h99; core_req = 1'b1;
    observe(10, 0, 1'b1, 0, 0, 8'h00);
    $display("drop_mid: acks=%0d wr_cnt=%0d", core_acks.size(), wr_cnt);
    checks++;
    if (core_acks.size() != 1 || core_acks[0] != 7 || wr_cnt != 4 || rd_cnt != 0) begin
      errors++; $display("FAIL drop_mid_ack: n=%0d at=%0d wr=%0d rd=%0d want 1 7 4 0",
                         core_acks.size(), core_acks[0], wr_cnt, rd_cnt);
    end
    checks++;
    if (a_at[5] !== 16'hA010 || dout_at[5] !== 8'h99) begin
      errors++; $display("FAIL drop_mid_latched: a5=%h d5=%h want a010 99", a_at[5], dout_at[5]);
    end
    core_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    core_addr = 16'hA123; core_we = 1'b1; core_wdata = 8'h11; core_req = 1'b1;
    @(negedge clk);
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_wr !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: bus_wr=%b want 1", bus_wr);
    end
    rst_n = 1'b0;
    #1;
    $display("reset_mid: wr=%b oe=%b a=%h", bus_wr, bus_oe, bus_a);
    checks++;
    if (bus_wr !== 1'b0 || bus_oe !== 1'b0 || bus_cs !== 1'b0 || bus_a !== 16'h0 ||
        bus_dout !== 8'h0 || core_ack !== 1'b0 || core_rdata !== 8'h0 || dbg_rdata !== 8'h0) begin
      errors++; $display("FAIL rst_mid_out: wr=%b oe=%b cs=%b a=%h d=%h ack=%b rd=%h/%h want all 0",
                         bus_wr, bus_oe, bus_cs, bus_a, bus_dout, core_ack, core_rdata, dbg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(10, 0, 1'b0, 0, 0, 8'h00);
    checks++;
    if (core_acks.size() != 0 || dbg_acks.size() != 0 || rd_cnt != 0 || wr_cnt != 0) begin
      errors++; $display("FAIL rst_mid_stale: acks=%0d/%0d rd=%0d wr=%0d want 0",
                         core_acks.size(), dbg_acks.size(), rd_cnt, wr_cnt);
    end
    core_addr = 16'h0042; core_we = 1'b0; core_req = 1'b1; bus_din = 8'hA1;
    observe(10, 0, 1'b0, 0, 6, 8'h5E);
    checks++;
    if (core_acks.size() != 1 || core_acks[0] != 7 || core_rdata !== 8'h5E) begin
      errors++; $display("FAIL rst_mid_after: n=%0d at=%0d rdata=%h want 1 7 5e",
                         core_acks.size(), core_acks[0], core_rdata);
    end
  endtask

  task automatic test_back_to_back();
    core_addr = 16'h0300; core_we = 1'b0; core_req = 1'b1; bus_din = 8'h00;
    observe(22, 1, 1'b0, 0, 0, 8'h00);
    $display("back_to_back: fast acks=%0d first@%0d second@%0d", f_acks.size(), f_acks[0], f_acks[1]);
    checks++;
    if (f_acks.size() < 2 || f_acks[0] != 3 || f_acks[1] != 7) begin
      errors++; $display("FAIL b2b_ack: n=%0d a0=%0d a1=%0d want 3 7", f_acks.size(), f_acks[0], f_acks[1]);
    end
    checks++;
    if (f_rd_at[4] !== 1'b0 || f_rd_at[5] !== 1'b1 || f_rd_at[3] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: rd3=%b rd4=%b rd5=%b want 0 0 1", f_rd_at[3], f_rd_at[4], f_rd_at[5]);
    end
    checks++;
    if (core_acks.size() != 2 || core_acks[0] != 7 || core_acks[1] != 15) begin
      errors++; $display("FAIL rereq_ack: n=%0d a0=%0d a1=%0d want 2 7 15",
                         core_acks.size(), core_acks[0], core_acks[1]);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_core_write();
    test_priority(1'b0);
    test_priority(1'b1);
    test_halt_mid();
    test_drop_mid();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_bus_arbiter.md
CART_BUS_ARBITER -- requirements
Module: cart_bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, address/cs setup cycles before strobe (legal 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4, rd/wr strobe cycles (legal 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, address/data hold cycles after strobe (legal 1..15).
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: halt  in  1  core halted; debug requester gets priority.
REQ-007 SHALL have ports: core_req  in  1, core_we  in  1, core_addr  in  16, core_wdata  in  8  core request (level).
REQ-008 SHALL have ports: core_ack  out  1, core_rdata  out  8  core completion pulse, read data.
REQ-009 SHALL have ports: dbg_req  in  1, dbg_we  in  1, dbg_addr  in  16, dbg_wdata  in  8  debug request (level).
REQ-010 SHALL have ports: dbg_ack  out  1, dbg_rdata  out  8  debug completion pulse, read data.
REQ-011 SHALL have ports: bus_a  out  16, bus_dout  out  8, bus_din  in  8, bus_oe  out  1  cartridge address/data; bus_oe enables data drive.
REQ-012 SHALL have ports: bus_rd  out  1, bus_wr  out  1, bus_cs  out  1  active-high strobes (inverted at pads by the top level).

Function
REQ-013 SHALL implement states IDLE, SETUP, STROBE, HOLD; one down-counter (4 bit) loaded on each state entry.
REQ-014 In IDLE, if a request is pending, SHALL grant, register addr/we/wdata of the winner, and enter SETUP next cycle.
REQ-015 Priority: halt=0 -> core over debug; halt=1 -> debug over core; a single pending requester always wins.
REQ-016 SHALL spend exactly SETUP_CYC, STROBE_CYC, HOLD_CYC cycles in SETUP, STROBE, HOLD, then return to IDLE.
REQ-017 bus_a SHALL equal the granted address from the first SETUP cycle through HOLD, and hold its last value in IDLE.
REQ-018 bus_cs SHALL be 1 during SETUP/STROBE/HOLD iff bus_a is in 0xA000..0xBFFF, else 0.
REQ-019 Read: bus_rd SHALL be 1 during SETUP and STROBE; bus_wr=0; bus_oe=0.
REQ-020 Write: bus_wr SHALL be 1 only during STROBE; bus_oe=1 and bus_dout=wdata from SETUP through HOLD; bus_rd=0.
REQ-021 Read data SHALL be captured from bus_din on the clock edge ending the last STROBE cycle into the granted requester's rdata register.
REQ-022 rdata registers SHALL hold their value until the next read completion for that requester; writes do not modify them.
REQ-023 Granted requester's ack SHALL be a one-cycle pulse during the last HOLD cycle; the other ack stays 0.
REQ-024 Latency: request seen in IDLE at cycle N -> ack at N+SETUP_CYC+STROBE_CYC+HOLD_CYC (defaults: N+7); IDLE at N+8.
REQ-025 One IDLE cycle SHALL always separate consecutive transactions; arbitration occurs only in IDLE.
REQ-026 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-027 A request dropped mid-transaction SHALL NOT abort it; the transaction completes and ack still pulses.
REQ-028 halt changing mid-transaction SHALL NOT affect the current transaction; it affects only the next arbitration.
REQ-029 Request inputs other than *_req SHALL be ignored except in the grant cycle.
REQ-030 In IDLE: bus_rd=bus_wr=bus_cs=bus_oe=0.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, bus_a=0x0000, bus_dout=0x00, bus_rd=bus_wr=bus_cs=bus_oe=0, core_ack=dbg_ack=0, core_rdata=dbg_rdata=0x00.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack; after release the arbiter starts in IDLE with no stale grant.

Verification
REQ-033 Core read 0x0150, bus_din=0x3C, halt=0, defaults -> bus_rd high 6 cycles, cs=0, core_ack at N+7, core_rdata=0x3C.
REQ-034 Core write 0xA000 data 0x5A -> cs=1 and oe=1 for 7 cycles, bus_wr high exactly 4 cycles, bus_dout=0x5A, core_ack at N+7.
REQ-035 core_req and dbg_req high together, halt=0 -> core served first, one IDLE cycle, then debug; with halt=1 -> debug first.
REQ-036 halt toggles 0->1 during STROBE of a core read -> core read completes unchanged; next grant goes to pending debug.
REQ-037 rst_n pulsed low during STROBE of a write -> bus_wr, bus_oe drop in same cycle, no ack, outputs at reset values, next request served normally.
REQ-038 SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 back-to-back core reads -> ack at N+3, next transaction SETUP at N+5.
